// File: rtl/xorbvelmaqu_pkg.sv
// xorbvelmaqu_pkg: shared types, sizes and index helper for the burst slot writer.
package xorbvelmaqu_pkg;
    localparam int NREQ  = 3;
    localparam int SLOTS = 18;
    localparam int IDXW  = 5;
    localparam int BLENW = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1} state_t;
    // Requesters are numbered 3..1; stepping below 1 wraps back to the top index.
    function automatic logic [1:0] prev_idx(input logic [1:0] k);
        return (k == 2'd1) ? 2'(NREQ) : k - 2'd1;
    endfunction
endpackage

// File: rtl/xorbvelmaqu_rrarb.sv
// xorbvelmaqu_rrarb: combinational round-robin picker, searching downward from the pointer.
import xorbvelmaqu_pkg::*;
module xorbvelmaqu_rrarb (
    input  logic [NREQ:1] req,
    input  logic [1:0]    ptr,
    output logic [NREQ:1] win,
    output logic [1:0]    widx,
    output logic          valid
);
    logic [1:0] c;
    always_comb begin
        c = ptr;
        widx = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[c]) begin
                valid = 1'b1;
                widx = c;
            end
            c = prev_idx(c);
        end
        win = valid ? NREQ'(1) << (widx - 2'd1) : '0;
    end
endmodule

// File: rtl/xorbvelmaqu.sv
// xorbvelmaqu: round-robin arbitrated burst writer into a shared wrapping slot array.
import xorbvelmaqu_pkg::*;
module xorbvelmaqu #(
    parameter int NREQ  = xorbvelmaqu_pkg::NREQ,
    parameter int SLOTS = xorbvelmaqu_pkg::SLOTS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ:1]              req,
    input  logic [NREQ:1][1:BLENW]     blen,
    input  logic [NREQ:1][1:2]         wdata,
    output logic [NREQ:1]              gnt,
    output logic                       slot_we,
    output logic [IDXW-1:0]            slot_idx,
    output logic [1:2]                 slot_data,
    output logic                       wrap,
    output logic                       busy
);
    state_t            state;
    logic [1:0]        own, ptr, widx;
    logic [BLENW-1:0]  len, cnt;
    logic [NREQ:1]     win;
    logic              valid;

    xorbvelmaqu_rrarb u_arb (.req(req), .ptr(ptr), .win(win), .widx(widx), .valid(valid));

    assign busy      = state != IDLE;
    assign slot_we   = state == XFER;
    assign slot_data = slot_we ? wdata[own] : '0;
    assign wrap      = slot_we && slot_idx == IDXW'(SLOTS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            own      <= 2'd1;
            ptr      <= 2'(NREQ);
            len      <= '0;
            cnt      <= '0;
            slot_idx <= '0;
        end else if (state == IDLE) begin
            if (valid) begin
                state <= XFER;
                gnt   <= win;
                own   <= widx;
                len   <= blen[widx];
                cnt   <= '0;
                ptr   <= prev_idx(widx);
            end
        end else begin
            slot_idx <= wrap ? '0 : slot_idx + 1'b1;
            cnt      <= cnt + 1'b1;
            // A dropped request still lets this beat land; the burst ends at this edge.
            if (cnt == len || !req[own]) begin
                state <= IDLE;
                gnt   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_xorbvelmaqu.sv
// tb_xorbvelmaqu: directed bursts checked every cycle against a behavioural arbitration/slot model.
module tb_xorbvelmaqu;
    logic            clk = 0, rst_n = 0;
    logic [3:1]      req = '0;
    logic [3:1][1:2] blen = '0, wdata = '0;
    logic [3:1]      gnt;
    logic            slot_we, wrap, busy;
    logic [4:0]      slot_idx;
    logic [1:2]      slot_data;
    int total = 0, bad = 0;
    bit en = 0;
    bit m_busy = 0;
    int m_own = 1, m_left = 0, m_slot = 0, m_ptr = 3;
    int glog[$];
    int wrap_cnt = 0;

    xorbvelmaqu dut (.clk(clk), .rst_n(rst_n), .req(req), .blen(blen), .wdata(wdata),
                     .gnt(gnt), .slot_we(slot_we), .slot_idx(slot_idx), .slot_data(slot_data),
                     .wrap(wrap), .busy(busy));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:1] r, input int p);
        for (int i = 0; i < 3; i++) begin
            int c = (p - 1 - i + 3) % 3 + 1;
            if (r[c]) return c;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_slot <= 0; m_ptr <= 3; m_left <= 0; m_own <= 1;
        end else if (!m_busy) begin
            if (pick(req, m_ptr) != 0) begin
                m_busy <= 1;
                m_own  <= pick(req, m_ptr);
                m_left <= int'(blen[pick(req, m_ptr)]) + 1;
                m_ptr  <= pick(req, m_ptr) == 1 ? 3 : pick(req, m_ptr) - 1;
            end
        end else begin
            m_slot <= (m_slot + 1) % 18;
            m_left <= m_left - 1;
            if (m_left == 1 || !req[m_own]) m_busy <= 0;
        end
    end

    initial begin
        int pg = 0;
        forever begin
            @(negedge clk);
            if (en) begin
                chk("gnt", int'(gnt), m_busy ? (1 << (m_own - 1)) : 0);
                chk("slot_we", int'(slot_we), int'(m_busy));
                chk("busy", int'(busy), int'(m_busy));
                chk("slot_idx", int'(slot_idx), m_slot);
                chk("slot_data", int'(slot_data), m_busy ? int'(wdata[m_own]) : 0);
                chk("wrap", int'(wrap), int'(m_busy && m_slot == 17));
                if (pg == 0 && gnt != 0) glog.push_back(gnt[3] ? 3 : gnt[2] ? 2 : 1);
                if (wrap) wrap_cnt++;
                pg = int'(gnt);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 0;
        req = '0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic burst(input int k, input int b, input int d);
        blen[k] = 2'(b);
        wdata[k] = 2'(d);
        req[k] = 1;
        tick();
        repeat (b) tick();
        req[k] = 0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        int s;
        tick();
        en = 1;
        do_reset();
        chk("reset_busy", int'(busy), 0);
        chk("reset_idx", int'(slot_idx), 0);
        // contention with all requesters held and single-beat bursts
        blen = '0;
        req = 3'b111;
        repeat (7) tick();
        req = '0;
        tick();
        chk("rr_count", glog.size(), 4);
        if (glog.size() >= 4) begin
            chk("rr0", glog[0], 3); chk("rr1", glog[1], 2);
            chk("rr2", glog[2], 1); chk("rr3", glog[3], 3);
        end
        // reset on beat 2 of 4
        blen[3] = 2'd3; wdata[3] = 2'b10; req[3] = 1;
        tick(); tick();
        rst_n = 0;
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_we", int'(slot_we), 0);
        chk("rst_data", int'(slot_data), 0);
        chk("rst_idx", int'(slot_idx), 0);
        req = '0;
        tick();
        rst_n = 1;
        tick();
        blen = '0;
        req = 3'b111;
        tick();
        chk("ptr_after_rst", int'(gnt), 3'b100);
        chk("idx_after_rst", int'(slot_idx), 0);
        req = '0;
        tick();
        // single request
        do_reset();
        burst(2, 2, 3);
        chk("single_idx", int'(slot_idx), 3);
        chk("single_gnt", int'(gnt), 0);
        // advance to slot 16 then wrap
        repeat (3) burst(3, 3, 1);
        burst(2, 0, 2);
        chk("pre_wrap_idx", int'(slot_idx), 16);
        wrap_cnt = 0;
        burst(1, 3, 2);
        chk("wrap_pulses", wrap_cnt, 1);
        chk("post_wrap_idx", int'(slot_idx), 2);
        // early drop during beat 2 of 4
        s = int'(slot_idx);
        blen[2] = 2'd3; wdata[2] = 2'b01; req[2] = 1;
        tick(); tick();
        req[2] = 0;
        tick();
        chk("drop_idx", int'(slot_idx), s + 2);
        chk("drop_busy", int'(busy), 0);
        // requester 1 ignored during requester 3 burst
        blen[3] = 2'd1; blen[1] = 2'd0; wdata[1] = 2'b11;
        req[3] = 1;
        tick();
        req[1] = 1;
        chk("ign_gnt0", int'(gnt), 3'b100);
        tick();
        req[3] = 0;
        chk("ign_gnt1", int'(gnt), 3'b100);
        tick();
        chk("ign_idle", int'(gnt), 0);
        tick();
        chk("ign_grant1", int'(gnt), 3'b001);
        chk("ign_data", int'(slot_data), 3);
        req = '0;
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xorbvelmaqu.md
XORBVELMAQU -- requirements
Module: xorbvelmaqu

Interface
REQ-001 Parameter NREQ, default 3: number of requesters, indexed [3:1].
REQ-002 Parameter SLOTS, default 18: slot count of the shared array (3 x 1 x 3 x 2 flattened), slot width 2 bits.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port req  input  logic [3:1]  per-requester access request, level.
REQ-006 Port blen  input  logic [3:1][1:2]  per-requester burst length minus one (0..3 => 1..4 beats).
REQ-007 Port wdata  input  logic [3:1][1:2]  per-requester write data, sampled each beat.
REQ-008 Port gnt  output  logic [3:1]  one-hot grant, zero when no burst active.
REQ-009 Port slot_we  output  bit  slot write strobe.
REQ-010 Port slot_idx  output  logic [4:0]  current target slot, 0..17.
REQ-011 Port slot_data  output  logic [1:2]  data for the current write.
REQ-012 Port wrap  output  bit  one-cycle pulse on the write to slot 17.
REQ-013 Port busy  output  bit  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, XFER; 2-bit encoding, no other reachable state.
REQ-015 IDLE: if any req bit set, winner chosen by round-robin, latched; next cycle state XFER with gnt = one-hot winner.
REQ-016 Round-robin: priority pointer names the highest-priority index; search order descends (3,2,1) from pointer, wrapping 1->3.
REQ-017 After a grant to index k, pointer becomes k-1 (wrapping 1->3), so k has lowest priority next arbitration.
REQ-018 Burst length latched from blen[k] at the grant decision; later changes to blen ignored for that burst.
REQ-019 XFER: each cycle slot_we=1, slot_data=wdata[k] (combinational from current-cycle input), slot_idx unchanged within the cycle, incremented after the edge.
REQ-020 slot_idx wraps 17->0; wrap=1 exactly in the cycle slot_we writes slot 17.
REQ-021 Beat counter counts latched length+1 beats; after the last beat state returns to IDLE, gnt=0.
REQ-022 Minimum one IDLE cycle between bursts (arbitration turnaround); back-to-back requests never produce consecutive-cycle grants to different requesters without it.
REQ-023 If req[k] drops during XFER, the current beat completes and the burst ends; next cycle IDLE.
REQ-024 Requests from non-granted indices during XFER are ignored until IDLE.
REQ-025 slot_idx persists across bursts; each burst resumes at the next unwritten slot.
REQ-026 In IDLE: slot_we=0, wrap=0, gnt=0, slot_data=0.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, gnt=0, slot_we=0, slot_idx=0, slot_data=0, wrap=0, busy=0, pointer=3, beat counter=0.
REQ-028 Reset during XFER aborts the burst immediately; no partial beat output after rst_n falls.
REQ-029 First arbitration after rst_n rises occurs no earlier than the first rising edge with rst_n high.

Structure
REQ-030 Shared package xorbvelmaqu_pkg holds the state enum, NREQ, SLOTS, slot-index width and blen width.
REQ-031 One sub-module xorbvelmaqu_rrarb: combinational round-robin picker (req, pointer -> one-hot winner, valid).
REQ-032 All sequential state in xorbvelmaqu; no latches; single always_ff on clk/negedge rst_n.

Verification
REQ-033 Single request: req=3'b010, blen[2]=2'd2, wdata[2]=2'b11 -> gnt=3'b010 one cycle later, 3 beats to slots 0,1,2, then IDLE, slot_idx=3.
REQ-034 Contention: req=3'b111 held, blen all 0 -> grants in order 3,2,1,3 with one IDLE cycle between each.
REQ-035 Wrap: preload slot_idx to 16 via prior bursts, burst blen=2'd3 -> writes slots 16,17,0,1; wrap=1 only on slot 17 beat.
REQ-036 Early drop: blen=2'd3, req deasserted after beat 2 -> exactly 2 beats written, slot_idx advanced by 2.
REQ-037 Reset mid-burst: rst_n low on beat 2 of 4 -> all outputs 0 that cycle, after release pointer=3 and slot_idx=0.
REQ-038 Ignored requester: requester 1 asserts during requester 3's XFER -> no gnt change until IDLE, then gnt=3'b001 granted.
